// File: rtl/mmio_bus_master_if.sv
// Request/response handshake and bus address/strobe signals of mmio_bus_master.
// The tri-state data lines stay a plain inout port on the master.
interface mmio_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic [63:0] address;
  logic        read;
  logic        write;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, address, read, write
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, address, read, write
  );
endinterface

// File: rtl/mmio_bus_master.sv
// Single-outstanding MMIO bus initiator: address setup, fixed-length strobe, valid/ready response.
// Define MMIO_RANGE_CHECK_EN to reject misaligned or out-of-window requests without a bus cycle.
module mmio_bus_master #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [63:0] BASE_ADDR   = 64'h10000000,
  parameter logic [63:0] WINDOW_MASK = 64'hFFFFFFFFFFFFFFF0
) (
  input  logic              clock,
  input  logic              reset,
  mmio_bus_master_if.master bus,
  inout  wire        [63:0] data
);

`ifdef MMIO_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  // Zero wait states is treated as one: the counter is loaded with W-1.
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        drive_data;
  logic        addr_ok;

  assign addr_ok = ((bus.req_addr & WINDOW_MASK) == BASE_ADDR) && (bus.req_addr[2:0] == 3'b000);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wr_d          = wr_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.address   = '0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    drive_data    = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wr_d    = bus.req_write;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          if (RANGE_CHECK && !addr_ok) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        bus.address = addr_q;
        drive_data  = wr_q;
        cnt_d       = CNT_LOAD;
        state_d     = ACCESS;
      end
      ACCESS: begin
        bus.address = addr_q;
        bus.read    = !wr_q;
        bus.write   = wr_q;
        drive_data  = wr_q;
        if (cnt_q == 4'd0) begin
          rdata_d = wr_q ? '0 : data;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign data          = drive_data ? wdata_q : 'z;

endmodule

// File: tb/tb_mmio_bus_master.sv
// Bench for mmio_bus_master: W=1 and W=3 instances, each with a GPIO-like peripheral on a pulled-up data bus.
`timescale 1ns/1ps
module tb_mmio_bus_master;
  localparam int NI = 2;
`ifdef MMIO_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        s_req_valid [NI];
  logic        s_req_write [NI];
  logic        s_rsp_ready [NI];
  logic [63:0] s_req_addr  [NI];
  logic [63:0] s_req_wdata [NI];
  logic        o_req_ready [NI];
  logic        o_rsp_valid [NI];
  logic        o_rsp_err   [NI];
  logic        o_read      [NI];
  logic        o_write     [NI];
  logic [63:0] o_rsp_rdata [NI];
  logic [63:0] o_address   [NI];
  logic [63:0] o_data      [NI];
  logic [63:0] preg        [NI][2];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic bit in_win(input logic [63:0] a);
    return (a & 64'hFFFF_FFFF_FFFF_FFF0) == 64'h1000_0000;
  endfunction

  function automatic int unsigned wait_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    mmio_bus_master_if bus ();
    wire [63:0] data_w;
    logic       p_drv;

    pullup pu_data (data_w);
    assign p_drv  = bus.read && in_win(bus.address);
    assign data_w = p_drv ? preg[g][bus.address[3]] : 'z;

    assign bus.req_valid = s_req_valid[g];
    assign bus.req_write = s_req_write[g];
    assign bus.req_addr  = s_req_addr[g];
    assign bus.req_wdata = s_req_wdata[g];
    assign bus.rsp_ready = s_rsp_ready[g];
    assign o_req_ready[g] = bus.req_ready;
    assign o_rsp_valid[g] = bus.rsp_valid;
    assign o_rsp_err[g]   = bus.rsp_err;
    assign o_rsp_rdata[g] = bus.rsp_rdata;
    assign o_address[g]   = bus.address;
    assign o_read[g]      = bus.read;
    assign o_write[g]     = bus.write;
    assign o_data[g]      = data_w;

    mmio_bus_master #(
      .WAIT_STATES ((g == 0) ? 1 : 3),
      .BASE_ADDR   (64'h1000_0000),
      .WINDOW_MASK (64'hFFFF_FFFF_FFFF_FFF0)
    ) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .data  (data_w)
    );
  end

  // Peripheral: two registers, loaded on every edge the write strobe is high.
  always @(posedge clock or negedge reset) begin
    for (int i = 0; i < NI; i++) begin
      if (!reset) begin
        preg[i][0] <= 64'hA5A5;
        preg[i][1] <= '0;
      end else if (o_write[i] && in_win(o_address[i])) begin
        preg[i][o_address[i][3]] <= o_data[i];
      end
    end
  end

  // Model: each transaction is tracked by its age in cycles since acceptance.
  bit          m_busy [NI];
  bit          m_acc  [NI];
  bit          m_wr   [NI];
  bit          m_err  [NI];
  bit          m_fresh[NI];
  int unsigned m_age  [NI];
  logic [63:0] m_addr [NI];
  logic [63:0] m_wdata[NI];
  logic [63:0] m_rdata[NI];
  logic [63:0] m_mem  [NI][2];

  function automatic int unsigned done_age(input int i);
    return m_err[i] ? 0 : wait_of(i) + 1;
  endfunction

  always @(posedge clock or negedge reset) begin
    for (int i = 0; i < NI; i++) begin
      m_acc[i] = 1'b0;
      if (!reset) begin
        m_busy[i]   = 1'b0;
        m_age[i]    = 0;
        m_fresh[i]  = 1'b1;
        m_mem[i][0] = 64'hA5A5;
        m_mem[i][1] = '0;
      end else if (!m_busy[i]) begin
        if (s_req_valid[i]) begin
          m_busy[i]  = 1'b1;
          m_acc[i]   = 1'b1;
          m_age[i]   = 0;
          m_wr[i]    = s_req_write[i];
          m_addr[i]  = s_req_addr[i];
          m_wdata[i] = s_req_wdata[i];
          m_rdata[i] = '0;
          m_err[i]   = RC && !(in_win(s_req_addr[i]) && s_req_addr[i][2:0] == 3'b000);
        end
      end else if (m_age[i] >= done_age(i)) begin
        if (s_rsp_ready[i]) begin
          m_busy[i]  = 1'b0;
          m_fresh[i] = 1'b0;
        end
      end else begin
        if (m_age[i] >= 1) begin
          if (m_wr[i] && in_win(m_addr[i])) m_mem[i][m_addr[i][3]] = m_wdata[i];
          if (!m_wr[i] && m_age[i] == wait_of(i))
            m_rdata[i] = in_win(m_addr[i]) ? m_mem[i][m_addr[i][3]] : ONES;
        end
        m_age[i]++;
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] t=%0t: got %h expected %h", nm, i, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < NI; i++) begin
      bit          dn, bus_on, acc, p_on;
      logic [63:0] exp_data;
      dn       = m_busy[i] && m_age[i] >= done_age(i);
      bus_on   = m_busy[i] && !dn;
      acc      = bus_on && m_age[i] >= 1;
      p_on     = acc && !m_wr[i] && in_win(m_addr[i]);
      exp_data = (bus_on && m_wr[i]) ? m_wdata[i] : p_on ? m_mem[i][m_addr[i][3]] : ONES;
      chk("req_ready", i, o_req_ready[i], !m_busy[i]);
      chk("rsp_valid", i, o_rsp_valid[i], dn);
      chk("address",   i, o_address[i],   bus_on ? m_addr[i] : '0);
      chk("read",      i, o_read[i],      acc && !m_wr[i]);
      chk("write",     i, o_write[i],     acc && m_wr[i]);
      chk("data",      i, o_data[i],      exp_data);
      if (dn) begin
        chk("rsp_rdata", i, o_rsp_rdata[i], (m_err[i] || m_wr[i]) ? '0 : m_rdata[i]);
        chk("rsp_err",   i, o_rsp_err[i],   m_err[i]);
      end else if (m_fresh[i] && !m_busy[i]) begin
        chk("rst_rdata", i, o_rsp_rdata[i], '0);
        chk("rst_err",   i, o_rsp_err[i],   '0);
      end
    end
  end

  task automatic issue(input int i, input bit wr, input logic [63:0] a, input logic [63:0] wd);
    bit ok;
    s_req_valid[i] = 1'b1;
    s_req_write[i] = wr;
    s_req_addr[i]  = a;
    s_req_wdata[i] = wd;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(posedge clock);
      #1;
      if (m_acc[i]) ok = 1'b1;
    end
    s_req_valid[i] = 1'b0;
    chk("accepted", i, ok, 1);
  endtask

  task automatic run(input int i, input bit wr, input logic [63:0] a, input logic [63:0] wd,
                     output int lat, output logic [63:0] rd, output logic err, output int stb);
    bit got;
    issue(i, wr, a, wd);
    lat = 0;
    stb = 0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clock);
      lat++;
      if (o_read[i] || o_write[i]) stb++;
      if (o_rsp_valid[i]) got = 1'b1;
    end
    rd  = o_rsp_rdata[i];
    err = o_rsp_err[i];
    for (int c = 0; c < 40 && m_busy[i]; c++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_idle(input int i);
    for (int c = 0; c < 40 && m_busy[i]; c++) begin
      @(posedge clock);
      #1;
    end
    chk("idle", i, m_busy[i], 0);
  endtask

  initial begin
    int          lat, stb;
    logic [63:0] rd;
    logic        err;
    for (int i = 0; i < NI; i++) begin
      s_req_valid[i] = 1'b0;
      s_req_write[i] = 1'b0;
      s_req_addr[i]  = '0;
      s_req_wdata[i] = '0;
      s_rsp_ready[i] = 1'b1;
    end
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("lit_reset_ready", 0, o_req_ready[0], 1);
    chk("lit_reset_valid", 1, o_rsp_valid[1], 0);
    chk("lit_reset_addr",  1, o_address[1],   '0);

    // Store W=1, then read the GPIO register back
    run(0, 1'b1, 64'h1000_0008, 64'hFF, lat, rd, err, stb);
    chk("lit_st_lat", 0, lat, 3);
    chk("lit_st_rd",  0, rd,  '0);
    chk("lit_st_stb", 0, stb, 1);
    chk("lit_gpio_dir", 0, preg[0][1], 64'hFF);
    run(0, 1'b0, 64'h1000_0008, '0, lat, rd, err, stb);
    chk("lit_ld1_rd",  0, rd,  64'hFF);
    chk("lit_ld1_lat", 0, lat, 3);

    // Load W=3
    run(1, 1'b0, 64'h1000_0000, '0, lat, rd, err, stb);
    chk("lit_ld3_rd",  1, rd,  64'hA5A5);
    chk("lit_ld3_lat", 1, lat, 5);
    chk("lit_ld3_stb", 1, stb, 3);

    // Backpressure with a second request already waiting
    s_rsp_ready[1] = 1'b0;
    issue(1, 1'b0, 64'h1000_0008, '0);
    for (int c = 0; c < 40 && !o_rsp_valid[1]; c++) @(negedge clock);
    s_req_valid[1] = 1'b1;
    s_req_write[1] = 1'b1;
    s_req_addr[1]  = 64'h1000_0008;
    s_req_wdata[1] = 64'h1234_5678_9ABC_DEF0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk("lit_bp_valid", 1, o_rsp_valid[1], 1);
      chk("lit_bp_ready", 1, o_req_ready[1], 0);
      chk("lit_bp_rdata", 1, o_rsp_rdata[1], '0);
    end
    s_rsp_ready[1] = 1'b1;
    @(negedge clock);
    chk("lit_bp_idle", 1, o_req_ready[1], 1);
    @(negedge clock);
    chk("lit_bp_next", 1, o_address[1], 64'h1000_0008);
    s_req_valid[1] = 1'b0;
    wait_idle(1);
    run(1, 1'b0, 64'h1000_0008, '0, lat, rd, err, stb);
    chk("lit_bp_st_rd", 1, rd, 64'h1234_5678_9ABC_DEF0);

    // Reset during the 2nd ACCESS cycle of a W=3 store
    issue(1, 1'b1, 64'h1000_0000, 64'h0000_0000_DEAD_BEEF);
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("lit_rst_write", 1, o_write[1],   0);
    chk("lit_rst_addr",  1, o_address[1], '0);
    chk("lit_rst_data",  1, o_data[1],    ONES);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("lit_rst_ready", 1, o_req_ready[1], 1);
    chk("lit_rst_valid", 1, o_rsp_valid[1], 0);
    run(1, 1'b0, 64'h1000_0000, '0, lat, rd, err, stb);
    chk("lit_post_rd", 1, rd, 64'hA5A5);

`ifdef MMIO_RANGE_CHECK_EN
    run(0, 1'b0, 64'h2000_0000, '0, lat, rd, err, stb);
    chk("lit_rc_out_lat", 0, lat, 1);
    chk("lit_rc_out_err", 0, err, 1);
    chk("lit_rc_out_stb", 0, stb, 0);
    run(0, 1'b1, 64'h1000_0004, 64'h77, lat, rd, err, stb);
    chk("lit_rc_mis_lat", 0, lat, 1);
    chk("lit_rc_mis_err", 0, err, 1);
    chk("lit_rc_mis_rd",  0, rd,  '0);
    run(0, 1'b0, 64'h1000_0000, '0, lat, rd, err, stb);
    chk("lit_rc_ok_err", 0, err, 0);
    chk("lit_rc_ok_rd",  0, rd,  64'hA5A5);
    chk("lit_rc_ok_lat", 0, lat, 3);
`else
    run(0, 1'b0, 64'h1000_0010, '0, lat, rd, err, stb);
    chk("lit_nowin_rd",  0, rd,  ONES);
    chk("lit_nowin_err", 0, err, 0);
    chk("lit_nowin_lat", 0, lat, 3);
`endif

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
